// File: rtl/core_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_lsu_pkg;

  // Access size encodings as decoded by the EXU; 2'b11 is reserved and behaves as word.
  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam int LSU_RSP_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  // Fields of an accepted request that are still needed after the EXU moves on.
  typedef struct packed {
    logic       is_store;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] a;
    logic [4:0] rd;
  } lsu_req_t;

  // Timeout counter must be able to hold the value RSP_TIMEOUT itself.
  function automatic int lsu_tmo_cnt_w(input int rsp_timeout);
    return $clog2(rsp_timeout + 1);
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering for stores, lane extract + sign/zero extend for loads, misalign detect.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size/is_unsigned/a select the access; wdata -> lane_wdata/wstrb (stores);
//        rdata -> load_data (loads); misalign flags half/word accesses off their natural boundary.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;

  // Shift the addressed lane down to bit 0 before extending.
  assign rd_byte_sh = rdata >> {a, 3'b000};
  assign rd_half_sh = rdata >> {a[1], 4'b0000};

  always_comb begin
    lane_wdata = wdata;
    wstrb      = 4'b1111;
    load_data  = rdata;
    misalign   = 1'b0;
    case (size)
      LSU_SIZE_B: begin
        lane_wdata = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << a;
        load_data  = {{24{rd_byte_sh[7] & ~is_unsigned}}, rd_byte_sh[7:0]};
      end
      LSU_SIZE_H: begin
        lane_wdata = {2{wdata[15:0]}};
        wstrb      = 4'b0011 << {a[1], 1'b0};
        load_data  = {{16{rd_half_sh[15] & ~is_unsigned}}, rd_half_sh[15:0]};
        misalign   = a[0];
      end
      default: begin
        // Word and the reserved encoding: data passes through untouched.
        misalign = (a != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one data-memory transaction at a time, lane-aligned store/load, fault flags.
// Latency: 3 cycles accept-to-done minimum (1 cycle for misaligned); response bounded by RSP_TIMEOUT.
// Backpressure: lsu_req_ready only in IDLE; dmem request held stable until dmem_req_ready.
// Ports: lsu_req_* from EXU; dmem_req_*/dmem_we/addr/wdata/wstrb to memory, dmem_rsp_* back;
//        lsu_done_* / lsu_misalign / lsu_bus_err to writeback, valid with the lsu_done pulse.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int RSP_TIMEOUT = LSU_RSP_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_is_store,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [4:0]  lsu_rd,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        lsu_done,
  output logic [4:0]  lsu_done_rd,
  output logic [31:0] lsu_done_data,
  output logic        lsu_done_wen,
  output logic        lsu_misalign,
  output logic        lsu_bus_err,
  output logic        lsu_busy
);

  localparam int CNT_W = lsu_tmo_cnt_w(RSP_TIMEOUT);

  lsu_state_t     state_q, state_d;
  lsu_req_t       req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic           tmo_hit;
  logic           in_idle;

  logic [1:0]     al_size;
  logic           al_unsigned;
  logic [1:0]     al_a;
  logic [31:0]    al_wdata;
  logic [3:0]     al_wstrb;
  logic [31:0]    al_load;
  logic           al_misalign;

  assign in_idle = (state_q == LSU_IDLE);

  // One align instance serves both directions: in IDLE it sees the live request
  // (store lanes, misalign check); afterwards it sees the latched request so the
  // response word is extracted with the original size/offset.
  assign al_size     = in_idle ? lsu_size     : req_q.size;
  assign al_unsigned = in_idle ? lsu_unsigned : req_q.is_unsigned;
  assign al_a        = in_idle ? lsu_addr[1:0] : req_q.a;

  core_lsu_align u_align (
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .a           (al_a),
    .wdata       (lsu_wdata),
    .rdata       (dmem_rsp_rdata),
    .lane_wdata  (al_wdata),
    .wstrb       (al_wstrb),
    .load_data   (al_load),
    .misalign    (al_misalign)
  );

  // Counter holds the number of completed WAIT cycles; the cycle that would make
  // it reach RSP_TIMEOUT is the last one a response is still honoured in.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo_hit = (cnt_inc == CNT_W'(RSP_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lsu_req_ready = 1'b0;
    lsu_done      = 1'b0;
    lsu_busy      = 1'b1;
    case (state_q)
      LSU_IDLE: begin
        lsu_req_ready = 1'b1;
        lsu_busy      = 1'b0;
        if (lsu_req_valid) begin
          state_d = al_misalign ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (dmem_req_ready) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmem_rsp_valid || tmo_hit) begin
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        lsu_done = 1'b1;
        state_d  = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // Datapath registers: request latch, memory request, timeout counter, completion record.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q          <= '0;
      cnt_q          <= '0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      lsu_done_rd    <= '0;
      lsu_done_data  <= '0;
      lsu_done_wen   <= 1'b0;
      lsu_misalign   <= 1'b0;
      lsu_bus_err    <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (lsu_req_valid) begin
            req_q <= '{is_store:    lsu_is_store,
                       size:        lsu_size,
                       is_unsigned: lsu_unsigned,
                       a:           lsu_addr[1:0],
                       rd:          lsu_rd};
            if (al_misalign) begin
              lsu_done_rd   <= lsu_rd;
              lsu_done_data <= '0;
              lsu_done_wen  <= 1'b0;
              lsu_misalign  <= 1'b1;
              lsu_bus_err   <= 1'b0;
            end else begin
              dmem_req_valid <= 1'b1;
              dmem_we        <= lsu_is_store;
              dmem_addr      <= {lsu_addr[31:2], 2'b00};
              dmem_wdata     <= lsu_is_store ? al_wdata : 32'd0;
              dmem_wstrb     <= lsu_is_store ? al_wstrb : 4'b0000;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            cnt_q          <= '0;
          end
        end
        LSU_WAIT: begin
          if (dmem_rsp_valid) begin
            lsu_done_rd   <= req_q.rd;
            lsu_done_data <= req_q.is_store ? 32'd0 : al_load;
            lsu_done_wen  <= ~req_q.is_store & (req_q.rd != 5'd0);
            lsu_misalign  <= 1'b0;
            lsu_bus_err   <= 1'b0;
          end else if (tmo_hit) begin
            lsu_done_rd   <= req_q.rd;
            lsu_done_data <= '0;
            lsu_done_wen  <= 1'b0;
            lsu_misalign  <= 1'b0;
            lsu_bus_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_is_store;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        lsu_done;
  logic [4:0]  lsu_done_rd;
  logic [31:0] lsu_done_data;
  logic        lsu_done_wen;
  logic        lsu_misalign;
  logic        lsu_bus_err;
  logic        lsu_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Completion record the bench expects to be held after the pulse.
  logic [31:0] held_data;
  logic [4:0]  held_rd;

  core_lsu #(.RSP_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_is_store   (lsu_is_store),
    .lsu_size       (lsu_size),
    .lsu_unsigned   (lsu_unsigned),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_rd         (lsu_rd),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .lsu_done       (lsu_done),
    .lsu_done_rd    (lsu_done_rd),
    .lsu_done_data  (lsu_done_data),
    .lsu_done_wen   (lsu_done_wen),
    .lsu_misalign   (lsu_misalign),
    .lsu_bus_err    (lsu_bus_err),
    .lsu_busy       (lsu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference load result from the architectural rules.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input int a, input logic [31:0] rdat);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rdat >> (8 * a)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdat >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rdat;
    end
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".rdy"},   32'(lsu_req_ready), 32'd1);
    check_eq({tag, ".busy"},  32'(lsu_busy), 32'd0);
    check_eq({tag, ".dvld"},  32'(dmem_req_valid), 32'd0);
    check_eq({tag, ".we"},    32'(dmem_we), 32'd0);
    check_eq({tag, ".daddr"}, dmem_addr, 32'd0);
    check_eq({tag, ".dwd"},   dmem_wdata, 32'd0);
    check_eq({tag, ".strb"},  32'(dmem_wstrb), 32'd0);
    check_eq({tag, ".done"},  32'(lsu_done), 32'd0);
    check_eq({tag, ".rd"},    32'(lsu_done_rd), 32'd0);
    check_eq({tag, ".data"},  lsu_done_data, 32'd0);
    check_eq({tag, ".wen"},   32'(lsu_done_wen), 32'd0);
    check_eq({tag, ".mis"},   32'(lsu_misalign), 32'd0);
    check_eq({tag, ".berr"},  32'(lsu_bus_err), 32'd0);
  endtask

  task automatic check_done(input logic [4:0] rd, input logic [31:0] data, input bit wen,
                            input bit mis, input bit berr);
    check_eq("done.pulse", 32'(lsu_done), 32'd1);
    check_eq("done.rd",    32'(lsu_done_rd), 32'(rd));
    check_eq("done.data",  lsu_done_data, data);
    check_eq("done.wen",   32'(lsu_done_wen), 32'(wen));
    check_eq("done.mis",   32'(lsu_misalign), 32'(mis));
    check_eq("done.berr",  32'(lsu_bus_err), 32'(berr));
    check_eq("done.rdy",   32'(lsu_req_ready), 32'd0);
    check_eq("done.dvld",  32'(dmem_req_valid), 32'd0);
    held_data = data;
    held_rd   = rd;
  endtask

  // Change the EXU-side fields while the unit is busy; the request stays valid.
  task automatic scramble();
    lsu_is_store = 1'($urandom);
    lsu_size     = 2'($urandom);
    lsu_unsigned = 1'($urandom);
    lsu_addr     = $urandom;
    lsu_wdata    = $urandom;
    lsu_rd       = 5'($urandom);
  endtask

  // One complete transaction. Entered and left at #1 after a rising edge with the unit idle.
  // rdy_dly: cycles dmem_req_ready stays low in REQ; rsp_dly: WAIT cycle index of the
  // response (>= TMO means no response and a bus error).
  task automatic do_op(input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                       input logic [4:0] rd, input int rdy_dly, input int rsp_dly,
                       input bit late_rsp);
    int  a;
    bit  mis;
    bit  got;
    int  w;
    logic [31:0] exp_wd;
    logic [31:0] exp_strb;
    a   = int'(addr & 32'd3);
    mis = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && a != 0);
    if (sz == 2'd0) begin
      exp_wd   = (wd & 32'hFF) * 32'h0101_0101;
      exp_strb = 32'd1 << a;
    end else if (sz == 2'd1) begin
      exp_wd   = (wd & 32'hFFFF) * 32'h0001_0001;
      exp_strb = 32'd3 << (2 * (a / 2));
    end else begin
      exp_wd   = wd;
      exp_strb = 32'hF;
    end
    if (!st) exp_strb = 32'd0;

    lsu_req_valid = 1'b1;
    lsu_is_store  = st;
    lsu_size      = sz;
    lsu_unsigned  = uns;
    lsu_addr      = addr;
    lsu_wdata     = wd;
    lsu_rd        = rd;
    @(negedge clk);
    check_eq("acc.rdy", 32'(lsu_req_ready), 32'd1);
    @(posedge clk); #1;
    scramble();

    if (mis) begin
      @(negedge clk);
      lsu_req_valid = 1'b0;
      check_done(rd, 32'd0, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        dmem_req_ready = (k == rdy_dly);
        @(negedge clk);
        check_eq("req.vld",  32'(dmem_req_valid), 32'd1);
        check_eq("req.rdy",  32'(lsu_req_ready), 32'd0);
        check_eq("req.we",   32'(dmem_we), 32'(st));
        check_eq("req.addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check_eq("req.strb", 32'(dmem_wstrb), exp_strb);
        if (st) check_eq("req.wdata", dmem_wdata, exp_wd);
        check_eq("req.done", 32'(lsu_done), 32'd0);
        @(posedge clk); #1;
      end
      dmem_req_ready = 1'($urandom);
      got = 1'b0;
      w   = 0;
      while (!got && w < TMO) begin
        if (w == rsp_dly) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rdat;
        end
        @(negedge clk);
        check_eq("wait.dvld", 32'(dmem_req_valid), 32'd0);
        check_eq("wait.done", 32'(lsu_done), 32'd0);
        check_eq("wait.busy", 32'(lsu_busy), 32'd1);
        @(posedge clk); #1;
        if (w == rsp_dly) got = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = $urandom;
        w++;
      end
      @(negedge clk);
      lsu_req_valid = 1'b0;
      if (got)
        check_done(rd, st ? 32'd0 : ref_load(sz, uns, a, rdat), !st && rd != 5'd0, 1'b0, 1'b0);
      else
        check_done(rd, 32'd0, 1'b0, 1'b0, 1'b1);
    end

    // Back in IDLE: optional stray response must be ignored, record must hold.
    @(posedge clk); #1;
    if (late_rsp) begin
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = $urandom;
    end
    @(negedge clk);
    check_eq("idle.done", 32'(lsu_done), 32'd0);
    check_eq("idle.busy", 32'(lsu_busy), 32'd0);
    check_eq("idle.dvld", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("hold.done", 32'(lsu_done), 32'd0);
    check_eq("hold.data", lsu_done_data, held_data);
    check_eq("hold.rd",   32'(lsu_done_rd), 32'(held_rd));
    @(posedge clk); #1;
  endtask

  initial begin
    rst            = 1'b1;
    lsu_req_valid  = 1'b0;
    lsu_is_store   = 1'b0;
    lsu_size       = 2'd0;
    lsu_unsigned   = 1'b0;
    lsu_addr       = 32'd0;
    lsu_wdata      = 32'd0;
    lsu_rd         = 5'd0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'd0;
    held_data      = 32'd0;
    held_rd        = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    do_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'd0,         32'hDEAD_BEEF, 5'd5,  0, 0, 1'b0);
    do_op(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'd0,         32'h80FF_1234, 5'd6,  0, 0, 1'b0);
    do_op(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0,         32'h80FF_1234, 5'd7,  0, 0, 1'b0);
    do_op(1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'd0,         32'h80FF_1234, 5'd8,  0, 0, 1'b0);
    do_op(1'b1, 2'd0, 1'b0, 32'h1000_0001, 32'h1234_56AB, 32'h5555_5555, 5'd9,  0, 1, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'd0,         32'h0,         5'd10, 0, 0, 1'b0);
    do_op(1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'hCAFE_F00D, 32'h0,         5'd11, 0, 0, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'h2000_0010, 32'd0,         32'h0,         5'd12, 3, 99, 1'b1);
    do_op(1'b0, 2'd2, 1'b0, 32'h2000_0014, 32'd0,         32'h1111_2222, 5'd0,  0, 0, 1'b0);
    do_op(1'b0, 2'd3, 1'b0, 32'h2000_0018, 32'd0,         32'h3333_4444, 5'd13, 1, TMO - 1, 1'b0);

    // Reset while waiting for a response; the response that follows is dropped.
    lsu_req_valid = 1'b1;
    lsu_is_store  = 1'b0;
    lsu_size      = 2'd2;
    lsu_addr      = 32'h3000_0000;
    lsu_rd        = 5'd3;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("rstw.busy", 32'(lsu_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h7777_7777;
    @(negedge clk);
    check_reset_vals("rst_wait");
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("rstw.done", 32'(lsu_done), 32'd0);
    check_eq("rstw.data", lsu_done_data, 32'd0);
    @(posedge clk); #1;
    held_data = 32'd0;
    held_rd   = 5'd0;
    do_op(1'b0, 2'd2, 1'b0, 32'h3000_0004, 32'd0, 32'hA5A5_0F0F, 5'd14, 0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ad;
      int          rsp;
      ad  = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & 32'hFFFF_FFFC | 32'($urandom_range(0, 3) & 32'd1) * 32'd0 | (ad & 32'd3) & 32'(($urandom_range(0, 1) == 0) ? 32'd0 : 32'd3);
      rsp = ($urandom_range(0, 7) == 0) ? TMO + 5 : int'($urandom_range(0, TMO - 1));
      do_op(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom, $urandom,
            5'($urandom), int'($urandom_range(0, 3)), rsp, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
